// File: rtl/fp_result_collector_pkg.sv
// Shared definitions for the FP multiplier result path: class codes,
// flag-bit positions and a small classification helper.
package fp_result_collector_pkg;

    // Class codes produced by fp_multiplication on num_value; 5-7 are reserved.
    typedef enum logic [2:0] {
        FP_ZERO      = 3'd0,
        FP_NORMAL    = 3'd1,
        FP_SUBNORMAL = 3'd2,
        FP_INF       = 3'd3,
        FP_NAN       = 3'd4
    } fp_class_e;

    localparam int CLASS_W  = 3;
    localparam int FLAG_W   = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    function automatic logic isNan(input logic [CLASS_W-1:0] code);
        return code == FP_NAN;
    endfunction

endpackage

// File: rtl/fp_result_collector_sync_fifo.sv
// Single-clock FIFO holding packed result entries. When empty, the read
// port shows the most recently popped entry (or zero after reset).
module sync_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_wr,
    input  logic                     i_rd,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [W-1:0]  r_hold;

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_wr) r_wptr <= r_wptr + PTR_ONE;
            if (i_rd) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Occupancy: simultaneous write and read leaves it unchanged.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_level <= '0;
        end else begin
            case ({i_wr, i_rd})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Remember the entry being popped so the outputs hold it once empty.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold <= '0;
        end else if (i_rd) begin
            r_hold <= r_mem[r_rptr];
        end
    end

    assign o_rdata = (r_level == '0) ? r_hold : r_mem[r_rptr];
    assign o_level = r_level;

endmodule

// File: rtl/fp_result_collector.sv
// Buffers multiplier products in a FIFO for a consumer with backpressure,
// and keeps sticky flags and saturating event counters on accepted products.
module fp_result_collector #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_result,
    input  logic [2:0]               in_num_value,
    input  logic                     in_over_flow,
    input  logic                     in_under_flow,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DW-1:0]            out_result,
    output logic [2:0]               out_num_value,
    output logic [1:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     drop,
    input  logic                     clr_stats,
    output logic                     sticky_ovf,
    output logic                     sticky_unf,
    output logic [CW-1:0]            ovf_count,
    output logic [CW-1:0]            unf_count,
    output logic [CW-1:0]            nan_count,
    output logic [CW-1:0]            drop_count
);

    import fp_result_collector_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = DW + FLAG_W + CLASS_W;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [LW-1:0]     w_level;
    logic [EW-1:0]     w_wdata;
    logic [EW-1:0]     w_rdata;
    logic [FLAG_W-1:0] w_inFlags;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_wr;
    logic              w_ovfEvt;
    logic              w_unfEvt;
    logic              w_nanEvt;
    logic              w_dropEvt;
    logic              r_drop;
    logic              r_stickyOvf;
    logic              r_stickyUnf;
    logic [CW-1:0]     r_ovfCount;
    logic [CW-1:0]     r_unfCount;
    logic [CW-1:0]     r_nanCount;
    logic [CW-1:0]     r_dropCount;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // Handshake decode: a full FIFO still accepts when it is popped in the same cycle.
    always_comb begin
        w_inFlags           = '0;
        w_inFlags[FLAG_OVF] = in_over_flow;
        w_inFlags[FLAG_UNF] = in_under_flow;
        w_full    = (w_level == LW'(DEPTH));
        w_empty   = (w_level == '0);
        w_pop     = en & ~w_empty & out_ready;
        w_wr      = en & in_valid & (~w_full | w_pop);
        w_dropEvt = en & in_valid & ~w_wr;
        w_ovfEvt  = w_wr & in_over_flow;
        w_unfEvt  = w_wr & in_under_flow;
        w_nanEvt  = w_wr & isNan(in_num_value);
        w_wdata   = {in_num_value, w_inFlags, in_result};
    end

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_wr      (w_wr),
        .i_rd      (w_pop),
        .i_wdata   (w_wdata),
        .o_rdata   (w_rdata),
        .o_level   (w_level)
    );

    // Drop pulse follows the lost product by one cycle; disabled cycles never drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_drop <= 1'b0;
        else          r_drop <= w_dropEvt;
    end

    // Sticky flags: a coincident event beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stickyOvf <= 1'b0;
            r_stickyUnf <= 1'b0;
        end else if (en) begin
            if (clr_stats) begin
                r_stickyOvf <= w_ovfEvt;
                r_stickyUnf <= w_unfEvt;
            end else begin
                if (w_ovfEvt) r_stickyOvf <= 1'b1;
                if (w_unfEvt) r_stickyUnf <= 1'b1;
            end
        end
    end

    // Saturating event counters: clear restarts at 1 when an event coincides.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovfCount  <= '0;
            r_unfCount  <= '0;
            r_nanCount  <= '0;
            r_dropCount <= '0;
        end else if (en) begin
            if (clr_stats) begin
                r_ovfCount  <= w_ovfEvt  ? CNT_ONE : '0;
                r_unfCount  <= w_unfEvt  ? CNT_ONE : '0;
                r_nanCount  <= w_nanEvt  ? CNT_ONE : '0;
                r_dropCount <= w_dropEvt ? CNT_ONE : '0;
            end else begin
                if (w_ovfEvt)  r_ovfCount  <= satInc(r_ovfCount);
                if (w_unfEvt)  r_unfCount  <= satInc(r_unfCount);
                if (w_nanEvt)  r_nanCount  <= satInc(r_nanCount);
                if (w_dropEvt) r_dropCount <= satInc(r_dropCount);
            end
        end
    end

    assign out_valid     = ~w_empty;
    assign out_result    = w_rdata[DW-1:0];
    assign out_flags     = w_rdata[DW+FLAG_W-1:DW];
    assign out_num_value = w_rdata[EW-1:DW+FLAG_W];
    assign level         = w_level;
    assign full          = w_full;
    assign empty         = w_empty;
    assign drop          = r_drop;
    assign sticky_ovf    = r_stickyOvf;
    assign sticky_unf    = r_stickyUnf;
    assign ovf_count     = r_ovfCount;
    assign unf_count     = r_unfCount;
    assign nan_count     = r_nanCount;
    assign drop_count    = r_dropCount;

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector: a vector table for single-cycle
// behaviour plus hand-written fill/drain, en gating, reset and saturation runs.
module tb_fp_result_collector;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          in_valid;
    logic [DW-1:0] in_result;
    logic [2:0]    in_num_value;
    logic          in_over_flow;
    logic          in_under_flow;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_result;
    logic [2:0]    out_num_value;
    logic [1:0]    out_flags;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          drop;
    logic          clr_stats;
    logic          sticky_ovf;
    logic          sticky_unf;
    logic [CW-1:0] ovf_count;
    logic [CW-1:0] unf_count;
    logic [CW-1:0] nan_count;
    logic [CW-1:0] drop_count;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic        inValid;
        logic [15:0] inResult;
        logic [2:0]  inNum;
        logic        inOvf;
        logic        inUnf;
        logic        outReady;
        logic        clr;
        logic        expValid;
        logic [15:0] expResult;
        logic [2:0]  expNum;
        logic [1:0]  expFlags;
        logic [3:0]  expLevel;
        logic [3:0]  expOvf;
        logic [3:0]  expUnf;
        logic [3:0]  expNan;
        logic        expSovf;
        logic        expSunf;
    } vec_t;

    vec_t vecs[11];

    fp_result_collector #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .in_valid      (in_valid),
        .in_result     (in_result),
        .in_num_value  (in_num_value),
        .in_over_flow  (in_over_flow),
        .in_under_flow (in_under_flow),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_result    (out_result),
        .out_num_value (out_num_value),
        .out_flags     (out_flags),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .drop          (drop),
        .clr_stats     (clr_stats),
        .sticky_ovf    (sticky_ovf),
        .sticky_unf    (sticky_unf),
        .ovf_count     (ovf_count),
        .unf_count     (unf_count),
        .nan_count     (nan_count),
        .drop_count    (drop_count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [15:0] r, input logic [2:0] n,
                                 input logic o, input logic u, input logic rdy,
                                 input logic c, input logic e);
        in_valid      = v;
        in_result     = r;
        in_num_value  = n;
        in_over_flow  = o;
        in_under_flow = u;
        out_ready     = rdy;
        clr_stats     = c;
        en            = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Main directed sequence.
    initial begin
        vecs[0]  = '{1'b1, 16'h3C00, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3C00, 3'd1, 2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3C00, 3'd1, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h7C00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7C00, 3'd3, 2'b10, 4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7C00, 3'd3, 2'b10, 4'd2, 4'd1, 4'd1, 4'd0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 16'h7E00, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7C00, 3'd3, 2'b10, 4'd3, 4'd1, 4'd1, 4'd1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 2'b01, 4'd2, 4'd1, 4'd1, 4'd1, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7E00, 3'd4, 2'b00, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 16'h7C00, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7C00, 3'd3, 2'b10, 4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7C00, 3'd3, 2'b10, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h1234, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 3'd5, 2'b00, 4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 3'd5, 2'b00, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0};

        reset_n       = 1'b0;
        en            = 1'b1;
        in_valid      = 1'b0;
        in_result     = '0;
        in_num_value  = '0;
        in_over_flow  = 1'b0;
        in_under_flow = 1'b0;
        out_ready     = 1'b0;
        clr_stats     = 1'b0;
        #12;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_drop", 32'(drop), 32'd0);
        checkOutput("rst_result", 32'(out_result), 32'd0);
        checkOutput("rst_num", 32'(out_num_value), 32'd0);
        checkOutput("rst_flags", 32'(out_flags), 32'd0);
        checkOutput("rst_counts", 32'({ovf_count, unf_count, nan_count, drop_count}), 32'd0);
        checkOutput("rst_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].inResult, vecs[i].inNum, vecs[i].inOvf,
                          vecs[i].inUnf, vecs[i].outReady, vecs[i].clr, 1'b1);
            checkOutput($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("v%0d_result", i), 32'(out_result), 32'(vecs[i].expResult));
            checkOutput($sformatf("v%0d_num", i), 32'(out_num_value), 32'(vecs[i].expNum));
            checkOutput($sformatf("v%0d_flags", i), 32'(out_flags), 32'(vecs[i].expFlags));
            checkOutput($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].expLevel));
            checkOutput($sformatf("v%0d_ovf", i), 32'(ovf_count), 32'(vecs[i].expOvf));
            checkOutput($sformatf("v%0d_unf", i), 32'(unf_count), 32'(vecs[i].expUnf));
            checkOutput($sformatf("v%0d_nan", i), 32'(nan_count), 32'(vecs[i].expNan));
            checkOutput($sformatf("v%0d_sovf", i), 32'(sticky_ovf), 32'(vecs[i].expSovf));
            checkOutput($sformatf("v%0d_sunf", i), 32'(sticky_unf), 32'(vecs[i].expSunf));
            checkOutput($sformatf("v%0d_drop", i), 32'(drop), 32'd0);
            checkOutput($sformatf("v%0d_dropcnt", i), 32'(drop_count), 32'd0);
        end

        // Fill with nine products while the consumer stalls; the ninth is lost.
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 16'(k), 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (k == 8) begin
                checkOutput("fill8_level", 32'(level), 32'd8);
                checkOutput("fill8_full", 32'(full), 32'd1);
                checkOutput("fill8_drop", 32'(drop), 32'd0);
            end
        end
        checkOutput("fill9_drop", 32'(drop), 32'd1);
        checkOutput("fill9_dropcnt", 32'(drop_count), 32'd1);
        checkOutput("fill9_level", 32'(level), 32'd8);
        applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("fill_drop_once", 32'(drop), 32'd0);
        checkOutput("fill_dropcnt_hold", 32'(drop_count), 32'd1);
        checkOutput("fill_head_stable", 32'(out_result), 32'h0001);

        // Drain and confirm order.
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("drain%0d_data", k), 32'(out_result), 32'(k));
            applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        // Refill, then push and pop together while full.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 16'(16'h0011 + k), 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("refill_full", 32'(full), 32'd1);
        applyStimulus(1'b1, 16'h0019, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("fullpop_drop", 32'(drop), 32'd0);
        checkOutput("fullpop_level", 32'(level), 32'd8);
        checkOutput("fullpop_head", 32'(out_result), 32'h0012);
        checkOutput("fullpop_dropcnt", 32'(drop_count), 32'd1);

        // Disabled cycles: nothing written, popped, dropped or counted.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 16'h0020, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("en0_%0d_drop", k), 32'(drop), 32'd0);
            checkOutput($sformatf("en0_%0d_level", k), 32'(level), 32'd8);
        end
        checkOutput("en0_head", 32'(out_result), 32'h0012);
        checkOutput("en0_dropcnt", 32'(drop_count), 32'd1);
        checkOutput("en0_ovf", 32'(ovf_count), 32'd1);
        checkOutput("en0_unf", 32'(unf_count), 32'd0);
        checkOutput("en0_nan", 32'(nan_count), 32'd0);

        // Bring the level to 5, then reset asynchronously between edges.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("pre_rst_level", 32'(level), 32'd5);
        checkOutput("pre_rst_head", 32'(out_result), 32'h0015);
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_level", 32'(level), 32'd0);
        checkOutput("arst_empty", 32'(empty), 32'd1);
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_result", 32'(out_result), 32'd0);
        checkOutput("arst_ovf", 32'(ovf_count), 32'd0);
        checkOutput("arst_dropcnt", 32'(drop_count), 32'd0);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 16'h00AB, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("post_rst_data", 32'(out_result), 32'h00AB);
        checkOutput("post_rst_level", 32'(level), 32'd1);

        // Counter saturation with a narrow counter width.
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b1, 16'h7C00, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("sat_ovf", 32'(ovf_count), 32'd15);
        checkOutput("sat_sovf", 32'(sticky_ovf), 32'd1);
        checkOutput("sat_level", 32'(level), 32'd1);
        checkOutput("sat_dropcnt", 32'(drop_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
